seq_mult_4x4: RTL and testbench
===============================

// Module: seq_mult_4x4
// PURPOSE
//  Sequential 4x4 unsigned shift-and-add multiplier with start/busy/done handshake.
//  Instantiates one four_bit_rca and reuses it once per cycle as the partial-product adder.
//  Produces an 8-bit product for datapath stages downstream of the combinational adders.
// PARAMETERS
//  WIDTH  4  operand width; only 4 is legal because four_bit_rca is fixed-width
// PORTS
//  clk      in   1  single clock; all state updates on rising edge
//  rst      in   1  synchronous, active-high reset
//  start    in   1  request; sampled only in IDLE
//  a        in   4  multiplicand; captured when start is accepted
//  b        in   4  multiplier; captured when start is accepted
//  busy     out  1  high whenever state != IDLE
//  done     out  1  one-cycle pulse; high in DONE
//  product  out  8  a*b; valid from the done cycle, held until the next accepted start
// BEHAVIOUR
//  - Reset (edge with rst=1): state=IDLE, busy=0, done=0, product=8'h00, count=0, M=0, P=0.
//    rst overrides all other inputs, including mid-operation; the aborted result is discarded.
//  - Registers: M[3:0] (multiplicand), P[7:0] = {U[3:0], Q[3:0]}, count[1:0].
//  - IDLE: start=1 -> M<=a, U<=0, Q<=b, count<=0, go to CALC. start=0 -> stay. Inputs otherwise ignored.
//  - CALC, one iteration per cycle: {c,s} = Q[0] ? rca(U,M,Cin=0) : {0,U};
//    P <= {c, s, Q[3:1]} (logical right shift, carry enters bit 7); count<=count+1.
//    When count==3 (4th iteration) -> DONE.
//  - DONE: product<=P (registered on the DONE-entry edge), done=1 for exactly one cycle,
//    then -> IDLE. start is ignored in CALC and DONE; no queuing.
//  - Timing: start high in cycle 0 (accepted at edge 1). Iterations at edges 2..5.
//    done=1 and product valid in cycle 5. busy=1 in cycles 1..5. Next start is accepted in cycle 6.
//  - Width rule: the 4-bit sum plus carry never overflows 8 bits. Max is 15*15 = 225 = 8'hE1.
//  - Adder Cin is tied 0. The rca Cout feeds bit 7 of the shifted P.
// CONFIGURATION
//  ZERO_SKIP_EN defined:
//    - In IDLE, an accepted start with a==0 or b==0 goes directly to DONE.
//    - product<=0 and done=1 in cycle 1.
//  ZERO_SKIP_EN undefined:
//    - Zero operands take the full path: done in cycle 5, product=0.
//    - Non-zero operands behave identically in both builds.
// STRUCTURE
//  - Shared package/header: state encoding IDLE=2'd0, CALC=2'd1, DONE=2'd2 (2'd3 is illegal and
//    recovers to IDLE); ITER_LAST=2'd3; PROD_W=2*WIDTH.
//  - Sub-module: one four_bit_rca instance, u_add, fed from (U, M, 1'b0).
//  - Everything else in one always block for state and datapath, plus a continuous-assign mux.
// TESTING
//  1 a=15,b=15, start in cycle 0 -> done=1 in cycle 5 only, product=8'hE1, busy=1 in cycles 1..5.
//  2 a=9,b=6 -> product=8'h36; then a=1,b=1 started in cycle 6 -> product=8'h01 in cycle 11.
//  3 start a=7,b=3; re-pulse start with a=2,b=2 in cycle 3 -> ignored; product=8'h15.
//  4 start a=12,b=5; rst=1 in cycle 3 -> cycle 4: busy=0, done=0, product=0, state IDLE;
//    no done pulse follows.
//  5 a=0,b=13: ZERO_SKIP_EN -> done in cycle 1, product=0; without it -> done in cycle 5, product=0.
//  6 Exhaustive sweep a,b in 0..15, back-to-back starts -> product==a*b for every pair;
//    done width is always 1 cycle.

Source files
------------

// File: rtl/seq_mult_4x4_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_mult_4x4_pkg
// Purpose : Shared types and constants for the sequential 4x4 multiplier:
//           controller state encoding, the final iteration index and the
//           operand/product widths.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
package seq_mult_4x4_pkg;

    // Operand width. The adder is a fixed 4-bit ripple-carry block, so this is
    // the only supported value.
    localparam int OP_W   = 4;
    localparam int PROD_W = 2 * OP_W;

    // Iteration count value at which the fourth (last) add/shift happens.
    localparam logic [1:0] ITER_LAST = 2'd3;

    // Controller states. Encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_mult_4x4_pkg
`default_nettype wire

// File: rtl/seq_mult_4x4_rca.sv
`default_nettype none
// ============================================================================
// Module  : four_bit_rca
// Purpose : 4-bit ripple-carry adder built from a chain of full adders.
// Ports   : i_a    [3:0] addend A
//           i_b    [3:0] addend B
//           i_cin        carry in
//           o_sum  [3:0] sum
//           o_cout       carry out of bit 3
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
module four_bit_rca (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    // w_carry[i] is the carry into bit i; w_carry[4] is the final carry out.
    logic [4:0] w_carry;

    assign w_carry[0] = i_cin;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            assign o_sum[gi]     = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (i_a[gi] & i_b[gi])
                                 | (i_a[gi] & w_carry[gi])
                                 | (i_b[gi] & w_carry[gi]);
        end
    endgenerate

    assign o_cout = w_carry[4];

endmodule : four_bit_rca
`default_nettype wire

// File: rtl/seq_mult_4x4.sv
`default_nettype none
// ============================================================================
// Module  : seq_mult_4x4
// Purpose : Sequential 4x4 unsigned shift-and-add multiplier with a
//           start/busy/done handshake. One four_bit_rca is reused once per
//           cycle as the partial-product adder; four iterations form the
//           8-bit product.
// Ports   : clk          clock, rising edge
//           rst          synchronous active-high reset
//           start        request, sampled only while idle
//           a     [3:0]  multiplicand, captured on accepted start
//           b     [3:0]  multiplier, captured on accepted start
//           busy         high whenever the controller is not idle
//           done         one-cycle completion pulse
//           product[7:0] a*b, valid from the done cycle, held afterwards
// Config  : ZERO_SKIP_EN - when defined, an accepted start with a zero
//           operand completes in one cycle with product 0.
// Revision: 1.0 - initial release
// ============================================================================
module seq_mult_4x4
    import seq_mult_4x4_pkg::*;
#(
    // Only 4 is legal: the shared adder is a fixed-width 4-bit block.
    parameter int WIDTH = OP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [PROD_W-1:0]  product
);

    state_t              r_state;
    logic [1:0]          r_count;
    logic [WIDTH-1:0]    r_m;        // captured multiplicand
    logic [PROD_W-1:0]   r_p;        // {U, Q}: upper accumulator, lower multiplier
    logic                r_busy;
    logic                r_done;
    logic [PROD_W-1:0]   r_product;

    logic [WIDTH-1:0]    w_sum;
    logic                w_cout;
    logic [WIDTH:0]      w_add;      // {carry, partial sum} entering the shift
    logic [PROD_W-1:0]   w_p_next;

    four_bit_rca u_add (
        .i_a    (r_p[PROD_W-1:WIDTH]),
        .i_b    (r_m),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Add M only when the current multiplier LSB is set, then shift the
    // whole {carry, U, Q} right by one; the carry lands in the product MSB.
    assign w_add    = r_p[0] ? {w_cout, w_sum} : {1'b0, r_p[PROD_W-1:WIDTH]};
    assign w_p_next = {w_add, r_p[WIDTH-1:1]};

`ifdef ZERO_SKIP_EN
    logic w_zero_op;
    assign w_zero_op = (a == '0) || (b == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= 2'd0;
            r_m       <= '0;
            r_p       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m     <= a;
                        r_p     <= {{WIDTH{1'b0}}, b};
                        r_count <= 2'd0;
                        r_busy  <= 1'b1;
`ifdef ZERO_SKIP_EN
                        if (w_zero_op) begin
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_product <= '0;
                        end else begin
                            r_state <= CALC;
                        end
`else
                        r_state <= CALC;
`endif
                    end
                end

                CALC: begin
                    r_p     <= w_p_next;
                    r_count <= r_count + 2'd1;
                    if (r_count == ITER_LAST) begin
                        // Product is taken from the final shifted value so it
                        // is valid in the same cycle done rises.
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_product <= w_p_next;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule : seq_mult_4x4
`default_nettype wire

// File: tb/tb_seq_mult_4x4.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_mult_4x4
// Purpose : Self-checking bench for seq_mult_4x4. Expected product is plain
//           a*b; expected timing is done exactly at the operation latency
//           (1 cycle for zero operands when ZERO_SKIP_EN, else 5 cycles).
// Ports   : none
// Config  : ZERO_SKIP_EN - must match the DUT build
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_mult_4x4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int n_assert;
    int n_fail;

    seq_mult_4x4 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs and samples sit 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int latency(input logic [3:0] x, input logic [3:0] y);
`ifdef ZERO_SKIP_EN
        if (x == 4'd0 || y == 4'd0) return 1;
`endif
        return 5;
    endfunction

    // Called in an idle cycle (cycle 0). Starts x*y, optionally drives random
    // garbage on start/a/b while busy, and returns in the first idle cycle
    // after done, with start low, so a new operation can begin immediately.
    task automatic run_op(input logic [3:0] x, input logic [3:0] y, input bit noise);
        int         lat;
        logic [7:0] exp_p;
        lat   = latency(x, y);
        exp_p = 8'(x) * 8'(y);
        start = 1'b1;
        a     = x;
        b     = y;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            step();
            if (noise) begin
                start = 1'($urandom);
                a     = 4'($urandom);
                b     = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            check("busy_during_op", 32'(busy), 32'd1);
            check("done_timing", 32'(done), (cyc == lat) ? 32'd1 : 32'd0);
            if (cyc == lat)
                check($sformatf("product_%0d_x_%0d", x, y), 32'(product), 32'(exp_p));
        end
        start = 1'b0;
        step();
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_single_pulse", 32'(done), 32'd0);
        check("product_held", 32'(product), 32'(exp_p));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        step();
        step();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        rst = 1'b0;
        step();

        // Maximum operands, then two back-to-back operations.
        run_op(4'd15, 4'd15, 1'b0);
        run_op(4'd9, 4'd6, 1'b0);
        run_op(4'd1, 4'd1, 1'b0);

        // Re-pulsed start while busy must be ignored.
        start = 1'b1; a = 4'd7; b = 4'd3;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            step();
            if (cyc == 3) begin
                start = 1'b1; a = 4'd2; b = 4'd2;
            end else begin
                start = 1'b0;
            end
            check("repulse_done", 32'(done), (cyc == 5) ? 32'd1 : 32'd0);
            if (cyc == 5) check("repulse_product", 32'(product), 32'h15);
        end
        start = 1'b0;
        step();

        // Reset mid-operation discards the result.
        start = 1'b1; a = 4'd12; b = 4'd5;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        rst = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            step();
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
        end

        // Zero operand path (latency depends on build).
        run_op(4'd0, 4'd13, 1'b0);

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                run_op(4'(i), 4'(j), 1'b0);

        // Random operands with random input activity while busy.
        for (int k = 0; k < 60; k++)
            run_op(4'($urandom), 4'($urandom), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_seq_mult_4x4
`default_nettype wire
